// File: rtl/grid_io_cfg_tile.sv
// ============================================================================
// Module   : grid_io_cfg_tile
// Brief    : IO grid tile holding a shadow configuration chain, a committed
//            active register, and the pad direction/invert/isolation muxes.
//            The optional macro GRID_IO_CFG_PARITY_EN appends an even-parity
//            bit to the chain and adds a parity check on commit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_io_cfg_tile #(
    parameter int NUM_IO   = 4,
    parameter int CFG_BITS = 2
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              ccff_head,
    input  logic              ccff_en,
    input  logic              ccff_commit,
    output logic              ccff_tail,
    output logic              cfg_valid,
    output logic              cfg_err,
    input  logic              isol_n,
    input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
    output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir,
    input  logic [NUM_IO-1:0] io_outpad,
    output logic [NUM_IO-1:0] io_inpad
);

    localparam int L  = NUM_IO * CFG_BITS;
`ifdef GRID_IO_CFG_PARITY_EN
    localparam int CL = L + 1;
`else
    localparam int CL = L;
`endif
    localparam int CW = $clog2(CL + 2);

    localparam logic [CW-1:0] CNT_FULL = CW'(CL);
    localparam logic [CW-1:0] CNT_SAT  = CW'(CL + 1);

    // Reset image of the active register: every IO an input, no inversion.
    function automatic logic [L-1:0] active_reset_value();
        logic [L-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            r[i*CFG_BITS] = 1'b1;
        end
        return r;
    endfunction

    localparam logic [L-1:0] ACTIVE_RST = active_reset_value();

    typedef enum logic [1:0] {
        UNCONF  = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CL-1:0]   shadow_q, shadow_d;
    logic [L-1:0]    active_q, active_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            commit_ok;

    // A commit is accepted only when exactly the chain length was shifted
    // (and, with parity enabled, the whole chain XORs to zero).
`ifdef GRID_IO_CFG_PARITY_EN
    assign commit_ok = (cnt_q == CNT_FULL) && ~(^shadow_q);
`else
    assign commit_ok = (cnt_q == CNT_FULL);
`endif

    // Next-state logic: commit has priority over shift in the same cycle.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        err_d    = err_q;
        if (ccff_commit) begin
            cnt_d = '0;
            if (commit_ok) begin
                active_d = shadow_q[L-1:0];
                valid_d  = 1'b1;
                err_d    = 1'b0;
                state_d  = READY;
            end else begin
                err_d   = 1'b1;
                state_d = valid_q ? READY : UNCONF;
            end
        end else if (ccff_en) begin
            if (CL > 1) begin
                shadow_d = {shadow_q[CL-2:0], ccff_head};
            end else begin
                shadow_d = CL'(ccff_head);
            end
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CW'(1);
            end
            state_d = LOADING;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state_q  <= UNCONF;
            shadow_q <= '0;
            active_q <= ACTIVE_RST;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign ccff_tail = shadow_q[CL-1];
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

    // Per-IO pad muxing; only dir (bit0) and inv (bit1) are interpreted.
    for (genvar i = 0; i < NUM_IO; i++) begin : g_io
        logic dir_w;
        logic inv_w;
        assign dir_w = active_q[i*CFG_BITS];
        assign inv_w = active_q[i*CFG_BITS+1];
        assign gfpga_pad_io_soc_dir[i] = isol_n ? dir_w : 1'b1;
        assign gfpga_pad_io_soc_out[i] = (isol_n & ~dir_w) ? (io_outpad[i] ^ inv_w) : 1'b0;
        assign io_inpad[i]             = (isol_n &  dir_w) ? (gfpga_pad_io_soc_in[i] ^ inv_w) : 1'b0;
    end

endmodule

`default_nettype wire

// File: tb/tb_grid_io_cfg_tile.sv
// ============================================================================
// Module   : tb_grid_io_cfg_tile
// Brief    : Directed self-checking bench for grid_io_cfg_tile
//            (NUM_IO=4, CFG_BITS=2, parity disabled).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_grid_io_cfg_tile;

    logic       prog_clk;
    logic       prog_reset;
    logic       ccff_head;
    logic       ccff_en;
    logic       ccff_commit;
    logic       ccff_tail;
    logic       cfg_valid;
    logic       cfg_err;
    logic       isol_n;
    logic [3:0] soc_in;
    logic [3:0] soc_out;
    logic [3:0] soc_dir;
    logic [3:0] io_outpad;
    logic [3:0] io_inpad;

    int n_tests;
    int n_fail;

    grid_io_cfg_tile #(
        .NUM_IO   (4),
        .CFG_BITS (2)
    ) dut (
        .prog_clk             (prog_clk),
        .prog_reset           (prog_reset),
        .ccff_head            (ccff_head),
        .ccff_en              (ccff_en),
        .ccff_commit          (ccff_commit),
        .ccff_tail            (ccff_tail),
        .cfg_valid            (cfg_valid),
        .cfg_err              (cfg_err),
        .isol_n               (isol_n),
        .gfpga_pad_io_soc_in  (soc_in),
        .gfpga_pad_io_soc_out (soc_out),
        .gfpga_pad_io_soc_dir (soc_dir),
        .io_outpad            (io_outpad),
        .io_inpad             (io_inpad)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Count one comparison and report it if the observed value differs.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One shift edge; inputs change 1 time unit after a rising edge.
    task automatic shift_bit(input logic b);
        ccff_head = b;
        ccff_en   = 1'b1;
        @(posedge prog_clk);
        #1;
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
    endtask

    // Shift n bits, pattern[0] first.
    task automatic shift_vec(input logic [15:0] pattern, input int n);
        for (int k = 0; k < n; k++) begin
            shift_bit(pattern[k]);
        end
    endtask

    task automatic commit(input logic with_en);
        ccff_commit = 1'b1;
        ccff_en     = with_en;
        ccff_head   = 1'b1;
        @(posedge prog_clk);
        #1;
        ccff_commit = 1'b0;
        ccff_en     = 1'b0;
        ccff_head   = 1'b0;
    endtask

    // Pattern 0,0,0,0,0,0,1,1 (first bit in bit 0): IO0 dir=1 inv=1.
    localparam logic [15:0] PAT_A = 16'b0000_0000_1100_0000;
    // Pattern 1,0,0,1,0,0,1,0: IO0 inv, IO2 dir, IO3 inv -> dir=0100.
    localparam logic [15:0] PAT_B = 16'b0000_0000_0100_1001;
    // Pattern 0,1,0,0,0,0,0,0,0: 2nd bit is the only 1.
    localparam logic [15:0] PAT_C = 16'b0000_0000_0000_0010;

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        prog_reset  = 1'b0;
        ccff_head   = 1'b0;
        ccff_en     = 1'b0;
        ccff_commit = 1'b0;
        isol_n      = 1'b1;
        soc_in      = 4'b0000;
        io_outpad   = 4'b0000;

        repeat (3) @(posedge prog_clk);
        #1;
        prog_reset = 1'b1;
        @(posedge prog_clk);
        #1;

        // Reset state.
        check_eq("rst_dir",   32'(soc_dir),   32'h0000000f);
        check_eq("rst_out",   32'(soc_out),   32'h0);
        check_eq("rst_inpad", 32'(io_inpad),  32'h0);
        check_eq("rst_valid", 32'(cfg_valid), 32'h0);
        check_eq("rst_err",   32'(cfg_err),   32'h0);

        // Good 8-bit load.
        shift_vec(PAT_A, 8);
        check_eq("a_valid_pre", 32'(cfg_valid), 32'h0);
        commit(1'b0);
        check_eq("a_valid", 32'(cfg_valid), 32'h1);
        check_eq("a_dir",   32'(soc_dir),   32'h1);
        soc_in    = 4'b0001;
        io_outpad = 4'b1010;
        #1;
        check_eq("a_inpad", 32'(io_inpad), 32'h0);
        check_eq("a_out",   32'(soc_out),  32'ha);

        // Short load rejected, active kept; then a good load with new pattern.
        shift_vec(16'h007f, 7);
        commit(1'b0);
        check_eq("short_err",   32'(cfg_err),   32'h1);
        check_eq("short_valid", 32'(cfg_valid), 32'h1);
        check_eq("short_dir",   32'(soc_dir),   32'h1);
        check_eq("short_out",   32'(soc_out),   32'ha);
        shift_vec(PAT_B, 8);
        commit(1'b0);
        check_eq("b_err", 32'(cfg_err), 32'h0);
        check_eq("b_dir", 32'(soc_dir), 32'h4);
        soc_in = 4'b0100;
        #1;
        check_eq("b_out",   32'(soc_out),  32'h3);
        check_eq("b_inpad", 32'(io_inpad), 32'h4);

        // Overrun: tail follows the chain, commit fails after saturation.
        shift_vec(PAT_C, 8);
        check_eq("ovr_tail8", 32'(ccff_tail), 32'h0);
        shift_bit(1'b0);
        check_eq("ovr_tail9", 32'(ccff_tail), 32'h1);
        check_eq("ovr_cnt",   32'(dut.cnt_q), 32'h9);
        commit(1'b0);
        check_eq("ovr_err", 32'(cfg_err), 32'h1);
        check_eq("ovr_dir", 32'(soc_dir), 32'h4);

        // Reload pattern A, committing with ccff_en also high (no shift).
        shift_vec(PAT_A, 8);
        commit(1'b1);
        check_eq("ce_err", 32'(cfg_err),   32'h0);
        check_eq("ce_dir", 32'(soc_dir),   32'h1);
        check_eq("ce_cnt", 32'(dut.cnt_q), 32'h0);

        // Isolation forces pads safe, release restores without reload.
        soc_in    = 4'b0001;
        io_outpad = 4'b1010;
        isol_n    = 1'b0;
        #1;
        check_eq("iso_dir",   32'(soc_dir),  32'hf);
        check_eq("iso_out",   32'(soc_out),  32'h0);
        soc_in = 4'b0000;
        #1;
        check_eq("iso_inpad", 32'(io_inpad), 32'h0);
        isol_n = 1'b1;
        #1;
        check_eq("iso_rel_dir",   32'(soc_dir),  32'h1);
        check_eq("iso_rel_out",   32'(soc_out),  32'ha);
        check_eq("iso_rel_inpad", 32'(io_inpad), 32'h1);

        // Asynchronous reset mid-load.
        shift_vec(16'h000f, 4);
        #2;
        prog_reset = 1'b0;
        #1;
        check_eq("mr_cnt",   32'(dut.cnt_q),   32'h0);
        check_eq("mr_state", 32'(dut.state_q), 32'h0);
        check_eq("mr_dir",   32'(soc_dir),     32'hf);
        check_eq("mr_valid", 32'(cfg_valid),   32'h0);
        check_eq("mr_tail",  32'(ccff_tail),   32'h0);
        @(posedge prog_clk);
        #1;
        prog_reset = 1'b1;
        shift_vec(PAT_A, 8);
        commit(1'b0);
        check_eq("mr_reload_valid", 32'(cfg_valid), 32'h1);
        check_eq("mr_reload_err",   32'(cfg_err),   32'h0);
        check_eq("mr_reload_dir",   32'(soc_dir),   32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/grid_io_cfg_tile.md
GRID_IO_CFG_TILE -- requirements
Module: grid_io_cfg_tile

Interface
REQ-001 SHALL have parameter NUM_IO, default 4, meaning the number of IO subtiles (1..32).
REQ-002 SHALL have parameter CFG_BITS, default 2, meaning config bits per IO: bit0 = dir (1 = pad is input), bit1 = inv (invert data).
REQ-003 SHALL have port prog_clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port prog_reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports ccff_head (input, 1), ccff_en (input, 1, shift strobe) and ccff_commit (input, 1, commit pulse).
REQ-006 SHALL have ports ccff_tail (output, 1), cfg_valid (output, 1) and cfg_err (output, 1).
REQ-007 SHALL have port isol_n, input, 1 bit: active-low pad isolation.
REQ-008 SHALL have ports gfpga_pad_io_soc_in (input, NUM_IO), gfpga_pad_io_soc_out (output, NUM_IO) and gfpga_pad_io_soc_dir (output, NUM_IO).
REQ-009 SHALL have ports io_outpad (input, NUM_IO, fabric to pad) and io_inpad (output, NUM_IO, pad to fabric).

Function
REQ-010 SHALL hold a shadow chain of L = NUM_IO*CFG_BITS bits (L+1 with parity; see REQ-024) and an active register of NUM_IO*CFG_BITS bits.
REQ-011 SHALL shift the chain on ccff_en=1 with no ccff_commit: shadow[0]<=ccff_head, shadow[k]<=shadow[k-1]; ccff_tail = shadow[top], taken directly from the register.
REQ-012 SHALL count shifts in cnt, saturating at L+1 (overrun), width clog2(L+2).
REQ-013 SHALL, on ccff_commit=1 with cnt==L: copy the shadow to the active register next edge, set cfg_valid=1, clear cfg_err and clear cnt.
REQ-014 SHALL, on ccff_commit=1 with cnt!=L: leave the active register unchanged, set cfg_err=1, clear cnt and leave cfg_valid unchanged.
REQ-015 SHALL, when ccff_commit=1 and ccff_en=1 in the same cycle: apply commit only, with no shift; the commit checks the pre-edge cnt.
REQ-016 SHALL implement states UNCONF, LOADING and READY: UNCONF->LOADING on ccff_en; LOADING->READY on a good commit; LOADING->UNCONF on a bad commit if cfg_valid=0, else ->READY; READY->LOADING on ccff_en.
REQ-017 SHALL keep cfg_valid=1 through a reload, since the active register keeps driving the pads.
REQ-018 SHALL map IO i to active[i*CFG_BITS +: CFG_BITS]; the last bit shifted lands in active[0] (IO0 dir).
REQ-019 SHALL drive gfpga_pad_io_soc_dir[i] = isol_n ? dir_i : 1, combinationally.
REQ-020 SHALL drive gfpga_pad_io_soc_out[i] = (isol_n & ~dir_i) ? io_outpad[i]^inv_i : 0.
REQ-021 SHALL drive io_inpad[i] = (isol_n & dir_i) ? gfpga_pad_io_soc_in[i]^inv_i : 0.
REQ-022 SHALL apply only bit0 and bit1 of each IO when CFG_BITS>2; the remaining bits are reserved, stored and ignored.

Reset
REQ-023 SHALL, while prog_reset=0: clear shadow, cnt, cfg_valid, cfg_err and ccff_tail; set state UNCONF; set each active dir=1 and inv=0 (all pads input); this applies immediately, including mid-shift.

Configuration
REQ-024 SHALL, with macro GRID_IO_CFG_PARITY_EN defined, append one parity bit so the chain is L+1 bits; commit SHALL require cnt==L+1 and even XOR over all shadow bits, otherwise behave as REQ-014.
REQ-025 SHALL, without GRID_IO_CFG_PARITY_EN, use a chain of L bits with no parity logic.

Verification (NUM_IO=4, CFG_BITS=2, no parity)
REQ-026 Release reset -> soc_dir=4'b1111, soc_out=0, io_inpad=0, cfg_valid=0, cfg_err=0.
REQ-027 Shift 0,0,0,0,0,0,1,1 then commit -> cfg_valid=1; soc_dir=4'b0001; soc_in[0]=1 gives io_inpad[0]=0; io_outpad=4'b1010 gives soc_out=4'b1010.
REQ-028 Shift 7 bits, then commit -> cfg_err=1, active and pads unchanged; a following 8-bit shift plus commit -> cfg_err=0.
REQ-029 Shift 9 bits -> ccff_tail equals the 2nd bit shifted after the 9th edge; commit -> cfg_err=1 (cnt saturated at 9).
REQ-030 Configured as in REQ-027, drive isol_n=0 -> soc_dir=4'b1111, soc_out=0, io_inpad=0; drive isol_n=1 -> prior values restored with no reload.
REQ-031 Assert reset after 4 shifts -> cnt=0, state UNCONF, all dir=1; a full 8-bit load then succeeds.
